seq_mul: RTL and testbench

SEQ_MUL -- requirements
Module: seq_mul

---
 rtl/seq_mul_pkg.sv | 14 +
 rtl/seq_mul_cla.sv | 43 ++++
 rtl/seq_mul.sv | 94 +++++++++
 tb/tb_seq_mul.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mul_pkg.sv
// Shared definitions for the 32x32 shift-add multiplier.
// Contents: FSM state type, iteration count, and step counter width.
package seq_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MUL_ITERS = 32;
  localparam int CNT_W     = 6;

endpackage

// File: rtl/seq_mul_cla.sv
// 32-bit carry-lookahead adder, sum only.
// Ports: a, b  - 32-bit addends
//        cin   - carry in
//        sum   - 32-bit sum
// Built from 4-bit lookahead groups. Each group's carry-out comes from the
// group generate/propagate terms. The top group has no carry-out, so bit 31
// generate is never formed.
module seq_mul_cla (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum
);

  logic [30:0] g;
  logic [31:0] p;
  logic [7:0]  cg;

  assign g     = a[30:0] & b[30:0];
  assign p     = a ^ b;
  assign cg[0] = cin;

  for (genvar k = 0; k < 8; k++) begin : g_grp
    logic [3:0] ci;

    assign ci[0] = cg[k];
    assign ci[1] = g[4*k] | (p[4*k] & ci[0]);
    assign ci[2] = g[4*k+1] | (p[4*k+1] & g[4*k]) |
                   (p[4*k+1] & p[4*k] & ci[0]);
    assign ci[3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) |
                   (p[4*k+2] & p[4*k+1] & g[4*k]) |
                   (p[4*k+2] & p[4*k+1] & p[4*k] & ci[0]);
    assign sum[4*k+3:4*k] = p[4*k+3:4*k] ^ ci;

    if (k < 7) begin : g_cout
      assign cg[k+1] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) |
                       (p[4*k+3] & p[4*k+2] & g[4*k+1]) |
                       (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]) |
                       (&p[4*k+3:4*k] & ci[0]);
    end
  end

endmodule

// File: rtl/seq_mul.sv
// Sequential 32x32 -> 64 unsigned multiplier (radix-2 shift-add).
// Latency is a fixed 32 cycles from acceptance to out_valid.
// Ports: clk, rst_n (async, active-low)
//        in_valid/in_ready, in_a, in_b      - operand handshake
//        out_valid/out_ready, out_prod      - product handshake
//
// state | meaning
// IDLE  | waiting for an operand pair; in_ready=1
// BUSY  | one shift-add step per edge, 32 steps total
// DONE  | product held on out_prod until out_ready
module seq_mul
  import seq_mul_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_prod
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_ITERS - 1);

  state_t           state_q, state_d;
  logic [31:0]      mcand_q, hi_q, lo_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      sum;
  logic             c33;
  logic [32:0]      acc;

  seq_mul_cla u_cla (
    .a   (hi_q),
    .b   (mcand_q),
    .cin (1'b0),
    .sum (sum)
  );

  // The adder exposes no carry-out. The carry into bit 31 is recovered as
  // sum^a^b at that bit, and the carry-out is the majority of that bit's inputs.
  always_comb begin
    logic c31;
    c31 = sum[31] ^ hi_q[31] ^ mcand_q[31];
    c33 = (hi_q[31] & mcand_q[31]) | (hi_q[31] & c31) | (mcand_q[31] & c31);
    acc = lo_q[0] ? {c33, sum} : {1'b0, hi_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = BUSY;
      BUSY:    if (cnt_q == LAST_CNT) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mcand_q <= in_a;
            lo_q    <= in_b;
            hi_q    <= '0;
            cnt_q   <= '0;
          end
        end
        BUSY: begin
          {hi_q, lo_q} <= {acc, lo_q[31:1]};
          cnt_q        <= cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_prod  = {hi_q, lo_q};

endmodule

// File: tb/tb_seq_mul.sv
module tb_seq_mul;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_prod;

  seq_mul dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] prod;
    int          edge_no;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          bp_mode  = 0;
  bit          seen     = 0;
  logic [63:0] held;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain 64-bit unsigned multiply.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] wa, wb;
    wa = {32'd0, a};
    wb = {32'd0, b};
    return wa * wb;
  endfunction

  // Consumer: out_ready policy per bp_mode (0 always, 1 random, 2 never).
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: on first sight of each product pop and compare value and
  // latency; while it is held, it must not change.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      if (!seen) begin
        if (q.size() == 0) begin
          check("unexpected_out_valid", 64'd1, 64'd0);
        end else begin
          exp_t it;
          it = q.pop_front();
          check("product", out_prod, it.prod);
          check("latency", 64'(cyc), 64'(it.edge_no + 32));
        end
        seen = 1;
        held = out_prod;
      end else begin
        check("held_product", out_prod, held);
      end
      if (out_ready) seen = 0;
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int  waited;
    bit  acc;
    waited = 0;
    acc    = 0;
    @(posedge clk);
    #1;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    while (!acc) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1;
        q.push_back('{prod: ref_mul(a, b), edge_no: cyc + 1});
      end else if (++waited > 1000) begin
        check("accept_timeout", 64'd1, 64'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || !in_ready) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_prod", out_prod, 64'd0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // 7*6 with in_ready low for the whole operation.
    send(32'd7, 32'd6);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check("in_ready_busy", 64'(in_ready), 64'd0);
    end
    drain();

    send(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    send(32'd0, 32'h1234_5678);
    send(32'h1234_5678, 32'd0);
    send(32'h8000_0000, 32'h8000_0000);
    drain();

    // Backpressure: hold out_ready low 10 cycles in DONE.
    bp_mode = 2;
    send(32'hDEAD_BEEF, 32'hCAFE_F00D);
    begin
      int n;
      n = 0;
      while (out_valid !== 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid_held", 64'(out_valid), 64'd1);
    end
    bp_mode = 0;
    repeat (2) @(negedge clk);
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    check("bp_release_out_valid", 64'(out_valid), 64'd0);
    drain();

    // in_valid activity during BUSY must not disturb the operation.
    send(32'h0001_2345, 32'h0006_789A);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'($urandom_range(0, 1));
      in_a     = $urandom;
      in_b     = $urandom;
    end
    in_valid = 1'b0;
    drain();

    // Reset at cnt=15 abandons the operation.
    send(32'hFFFF_FFFF, 32'h0F0F_0F0F);
    repeat (15) @(posedge clk);
    #3;
    rst_n = 1'b0;
    q.delete();
    seen = 0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_prod", out_prod, 64'd0);
    #10;
    @(negedge clk);
    rst_n = 1'b1;
    send(32'd123_456, 32'd654_321);
    drain();

    // Random run with random backpressure.
    bp_mode = 1;
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] a, b;
      case ($urandom_range(0, 9))
        0:       a = 32'd0;
        1:       a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      send(a, b);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
